// File: rtl/ctrl_fsm_param_pkg.sv
// Shared constants for the parametrised control unit: opcodes, states,
// ALU / memory / mux2 codes and small opcode classification helpers.
package ctrl_fsm_param_pkg;

   typedef enum logic [3:0] {
      OP_CLR   = 4'd0,
      OP_LOAD  = 4'd1,
      OP_STORE = 4'd2,
      OP_COPY  = 4'd3,
      OP_INCR  = 4'd4,
      OP_ADDI  = 4'd5,
      OP_ADDR  = 4'd6,
      OP_SUBI  = 4'd7,
      OP_SUBR  = 4'd8,
      OP_SHL   = 4'd9,
      OP_SHR   = 4'd10,
      OP_JPNZ  = 4'd11,
      OP_OR    = 4'd12,
      OP_JPZ   = 4'd13,
      OP_HALT  = 4'd14,
      OP_NOOP  = 4'd15
   } opcode_t;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_FETCH   = 4'd1,
      ST_DECODE  = 4'd2,
      ST_OPERAND = 4'd3,
      ST_EXEC    = 4'd4,
      ST_MEM     = 4'd5,
      ST_HALT    = 4'd6,
      ST_ERR     = 4'd7
   } state_t;

   localparam logic [3:0] ALU_NONE = 4'd0;
   localparam logic [3:0] ALU_ABUS = 4'd1;
   localparam logic [3:0] ALU_INCR = 4'd2;
   localparam logic [3:0] ALU_ADD  = 4'd3;
   localparam logic [3:0] ALU_SUB  = 4'd4;
   localparam logic [3:0] ALU_SHL  = 4'd5;
   localparam logic [3:0] ALU_SHR  = 4'd6;
   localparam logic [3:0] ALU_OR   = 4'd7;

   localparam logic [1:0] MEM_NONE     = 2'd0;
   localparam logic [1:0] MEM_IM_READ  = 2'd1;
   localparam logic [1:0] MEM_DM_READ  = 2'd2;
   localparam logic [1:0] MEM_DM_WRITE = 2'd3;

   localparam logic [1:0] MUX2_NONE = 2'd0;
   localparam logic [1:0] MUX2_IMM  = 2'd1;

   // Selects are truncated to the operand-field width at the use site;
   // truncating all-ones keeps CSEL_PC all-ones at any width.
   localparam logic [31:0] SEL_NONE = '0;
   localparam logic [31:0] CSEL_PC  = '1;

   // Ops that carry a second (dst/src) instruction word.
   function automatic logic two_word(input opcode_t op);
      return op inside {OP_COPY, OP_ADDI, OP_ADDR, OP_SUBI,
                        OP_SUBR, OP_SHL, OP_SHR, OP_OR};
   endfunction

   function automatic logic [3:0] alu_of(input opcode_t op);
      case (op)
         OP_INCR:                  return ALU_INCR;
         OP_ADDI, OP_ADDR:         return ALU_ADD;
         OP_SUBI, OP_SUBR:         return ALU_SUB;
         OP_SHL:                   return ALU_SHL;
         OP_SHR:                   return ALU_SHR;
         OP_OR:                    return ALU_OR;
         OP_COPY, OP_JPNZ, OP_JPZ: return ALU_ABUS;
         default:                  return ALU_NONE;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_fsm_param_wait_timer.sv
// Memory wait timer: counts cycles spent waiting on mem_ready.
// Ports: clk, rst_n, clr (restart), en (count), expire (last cycle, en high).
module ctrl_wait_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(LIMIT);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign expire = en && (count == LAST);

endmodule

// File: rtl/ctrl_fsm_param.sv
// Multicycle control unit with start/done/busy handshake and memory timeout.
// Ports: clk, rst_n, start, instr, z_flag, mem_ready in; Moore strobes out.
module ctrl_fsm_param
   import ctrl_fsm_param_pkg::*;
#(
   parameter int INSTR_W     = 8,
   parameter int ALU_OP_W    = 4,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [INSTR_W-1:0]    instr,
   input  logic                  z_flag,
   input  logic                  mem_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  pc_inc,
   output logic                  rst_en,
   output logic [INSTR_W/2-1:0]  rst_sel,
   output logic [INSTR_W/2-1:0]  a_sel,
   output logic [INSTR_W/2-1:0]  b_sel,
   output logic [INSTR_W/2-1:0]  c_sel,
   output logic [ALU_OP_W-1:0]   alu_op,
   output logic [1:0]            mem_op,
   output logic                  ir_en,
   output logic                  branch,
   output logic [1:0]            mux2_ctrl,
   output logic [3:0]            state
);

   localparam int HW = INSTR_W / 2;

   state_t         st, nxt;
   opcode_t        opc_q;
   logic [HW-1:0]  op_q, dst_q, src_q;
   opcode_t        in_opc;
   logic           waiting, expire;

   // Opcode fields wider than 4 bits with upper bits set are unused: NOOP.
   function automatic opcode_t decode_opc(input logic [HW-1:0] f);
      if ((f >> 4) != '0) return OP_NOOP;
      return opcode_t'(f[3:0]);
   endfunction

   assign in_opc  = decode_opc(instr[INSTR_W-1:HW]);
   assign waiting = st inside {ST_FETCH, ST_OPERAND, ST_MEM};

   // Counter is zero on every entry to a wait state because it is held
   // clear outside them and cleared on the completing (mem_ready) cycle.
   ctrl_wait_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (!waiting || mem_ready),
      .en     (waiting && !mem_ready),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= ST_IDLE;
      end else begin
         st <= nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opc_q <= OP_CLR;
         op_q  <= '0;
         dst_q <= '0;
         src_q <= '0;
      end else begin
         if (st == ST_DECODE) begin
            opc_q <= in_opc;
            op_q  <= instr[HW-1:0];
         end
         if (st == ST_OPERAND && mem_ready) begin
            dst_q <= instr[INSTR_W-1:HW];
            src_q <= instr[HW-1:0];
         end
      end
   end

   always_comb begin
      nxt = st;
      case (st)
         ST_IDLE, ST_ERR: begin
            if (start) nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ready)   nxt = ST_DECODE;
            else if (expire) nxt = ST_ERR;
         end
         ST_DECODE: begin
            if (in_opc inside {OP_LOAD, OP_STORE})
               nxt = ST_MEM;
            else if (two_word(in_opc))
               nxt = ST_OPERAND;
            else if (in_opc == OP_JPNZ)
               nxt = z_flag ? ST_FETCH : ST_EXEC;
            else if (in_opc == OP_JPZ)
               nxt = z_flag ? ST_EXEC : ST_FETCH;
            else if (in_opc == OP_HALT)
               nxt = ST_HALT;
            else
               nxt = ST_EXEC;
         end
         ST_OPERAND: begin
            if (mem_ready)   nxt = ST_EXEC;
            else if (expire) nxt = ST_ERR;
         end
         ST_MEM: begin
            if (mem_ready)   nxt = ST_FETCH;
            else if (expire) nxt = ST_ERR;
         end
         ST_EXEC: nxt = ST_FETCH;
         ST_HALT: nxt = ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = !(st inside {ST_IDLE, ST_ERR});
      done      = (st == ST_HALT);
      err       = (st == ST_ERR);
      pc_inc    = 1'b0;
      rst_en    = 1'b0;
      rst_sel   = HW'(SEL_NONE);
      a_sel     = HW'(SEL_NONE);
      b_sel     = HW'(SEL_NONE);
      c_sel     = HW'(SEL_NONE);
      alu_op    = ALU_OP_W'(ALU_NONE);
      mem_op    = MEM_NONE;
      ir_en     = 1'b0;
      branch    = 1'b0;
      mux2_ctrl = MUX2_NONE;
      state     = st;
      case (st)
         ST_FETCH, ST_OPERAND: begin
            mem_op = MEM_IM_READ;
            ir_en  = 1'b1;
         end
         ST_DECODE: pc_inc = 1'b1;
         ST_MEM: begin
            mem_op = (opc_q == OP_STORE) ? MEM_DM_WRITE : MEM_DM_READ;
         end
         ST_EXEC: begin
            pc_inc = two_word(opc_q);
            alu_op = ALU_OP_W'(alu_of(opc_q));
            case (opc_q)
               OP_CLR: begin
                  rst_en  = 1'b1;
                  rst_sel = op_q;
               end
               OP_INCR: begin
                  a_sel = op_q;
                  c_sel = op_q;
               end
               OP_COPY: begin
                  a_sel = src_q;
                  c_sel = dst_q;
               end
               OP_ADDI, OP_SUBI, OP_SHL, OP_SHR: begin
                  a_sel     = dst_q;
                  c_sel     = dst_q;
                  mux2_ctrl = MUX2_IMM;
               end
               OP_ADDR, OP_SUBR, OP_OR: begin
                  a_sel = dst_q;
                  b_sel = src_q;
                  c_sel = dst_q;
               end
               OP_JPNZ, OP_JPZ: begin
                  a_sel  = op_q;
                  c_sel  = HW'(CSEL_PC);
                  branch = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Directed bench for ctrl_fsm_param: handshake, operand fetch, branches,
// memory stall, timeout/error recovery, HALT and asynchronous reset.
module tb_ctrl_fsm_param;
   import ctrl_fsm_param_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] instr;
   logic       z_flag;
   logic       mem_ready;
   logic       busy, done, err, pc_inc, rst_en, ir_en, branch;
   logic [3:0] rst_sel, a_sel, b_sel, c_sel, alu_op, state;
   logic [1:0] mem_op, mux2_ctrl;

   int vecs = 0;
   int errs = 0;

   ctrl_fsm_param #(
      .INSTR_W     (8),
      .ALU_OP_W    (4),
      .MEM_TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .instr     (instr),
      .z_flag    (z_flag),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .pc_inc    (pc_inc),
      .rst_en    (rst_en),
      .rst_sel   (rst_sel),
      .a_sel     (a_sel),
      .b_sel     (b_sel),
      .c_sel     (c_sel),
      .alu_op    (alu_op),
      .mem_op    (mem_op),
      .ir_en     (ir_en),
      .branch    (branch),
      .mux2_ctrl (mux2_ctrl),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; instr = 8'h00;
      z_flag = 1'b0; mem_ready = 1'b0;
      step(); step();
      chk("rst_state", 32'(state), 32'(ST_IDLE));
      chk("rst_busy", 32'(busy), 0);
      chk("rst_memop", 32'(mem_op), 32'(MEM_NONE));
      chk("rst_alu", 32'(alu_op), 32'(ALU_NONE));
      chk("rst_err", 32'(err), 0);
      rst_n = 1'b1;
      step();
      chk("idle_hold", 32'(state), 32'(ST_IDLE));

      // ADDR r2,r3: two-word op
      start = 1'b1; mem_ready = 1'b1; instr = 8'h60;
      step();
      start = 1'b0;
      chk("addr_fetch", 32'(state), 32'(ST_FETCH));
      chk("addr_fetch_mem", 32'(mem_op), 32'(MEM_IM_READ));
      chk("addr_fetch_ir", 32'(ir_en), 1);
      chk("addr_fetch_busy", 32'(busy), 1);
      step();
      chk("addr_decode", 32'(state), 32'(ST_DECODE));
      chk("addr_decode_pc", 32'(pc_inc), 1);
      step();
      chk("addr_operand", 32'(state), 32'(ST_OPERAND));
      instr = 8'h23;
      step();
      chk("addr_exec", 32'(state), 32'(ST_EXEC));
      chk("addr_a", 32'(a_sel), 2);
      chk("addr_b", 32'(b_sel), 3);
      chk("addr_c", 32'(c_sel), 2);
      chk("addr_alu", 32'(alu_op), 32'(ALU_ADD));
      chk("addr_pc", 32'(pc_inc), 1);
      chk("addr_mux2", 32'(mux2_ctrl), 32'(MUX2_NONE));
      step();
      chk("addr_back", 32'(state), 32'(ST_FETCH));

      // JPNZ taken (z=0)
      instr = 8'hB5; z_flag = 1'b0;
      step(); step();
      chk("jpnz_exec", 32'(state), 32'(ST_EXEC));
      chk("jpnz_branch", 32'(branch), 1);
      chk("jpnz_a", 32'(a_sel), 5);
      chk("jpnz_c", 32'(c_sel), 32'h0F);
      chk("jpnz_alu", 32'(alu_op), 32'(ALU_ABUS));
      chk("jpnz_pc", 32'(pc_inc), 0);
      step(); step();
      chk("jpnz2_decode", 32'(state), 32'(ST_DECODE));
      z_flag = 1'b1;
      step();
      chk("jpnz_nt_state", 32'(state), 32'(ST_FETCH));
      chk("jpnz_nt_branch", 32'(branch), 0);

      // LOAD with 5-cycle stall: DM_READ for 6 cycles
      instr = 8'h13; z_flag = 1'b0;
      step(); step();
      mem_ready = 1'b0;
      chk("load_mem1", 32'(mem_op), 32'(MEM_DM_READ));
      for (int i = 2; i <= 6; i++) begin
         step();
         chk("load_mem_state", 32'(state), 32'(ST_MEM));
         chk("load_mem_op", 32'(mem_op), 32'(MEM_DM_READ));
      end
      mem_ready = 1'b1;
      step();
      chk("load_done", 32'(state), 32'(ST_FETCH));
      chk("load_err", 32'(err), 0);

      // FETCH timeout after 16 cycles
      mem_ready = 1'b0;
      for (int i = 1; i <= 15; i++) step();
      chk("to_15_state", 32'(state), 32'(ST_FETCH));
      chk("to_15_err", 32'(err), 0);
      step();
      chk("to_err_state", 32'(state), 32'(ST_ERR));
      chk("to_err", 32'(err), 1);
      chk("to_err_busy", 32'(busy), 0);
      chk("to_err_mem", 32'(mem_op), 32'(MEM_NONE));
      start = 1'b1;
      step();
      start = 1'b0;
      chk("err_restart", 32'(state), 32'(ST_FETCH));
      chk("err_clear", 32'(err), 0);

      // HALT, with start asserted during execution
      mem_ready = 1'b1; instr = 8'hE0;
      step();
      start = 1'b1;
      step();
      chk("halt_state", 32'(state), 32'(ST_HALT));
      chk("halt_done", 32'(done), 1);
      chk("halt_busy", 32'(busy), 1);
      step();
      start = 1'b0;
      chk("halt_idle", 32'(state), 32'(ST_IDLE));
      chk("halt_done_off", 32'(done), 0);
      chk("halt_busy_off", 32'(busy), 0);
      step();
      chk("halt_stay_idle", 32'(state), 32'(ST_IDLE));

      // CLR r7
      start = 1'b1; instr = 8'h07;
      step();
      start = 1'b0;
      step(); step();
      chk("clr_exec", 32'(state), 32'(ST_EXEC));
      chk("clr_rst_en", 32'(rst_en), 1);
      chk("clr_rst_sel", 32'(rst_sel), 7);
      chk("clr_pc", 32'(pc_inc), 0);
      step();

      // STORE, async reset while stalled in MEM
      instr = 8'h24;
      step(); step();
      mem_ready = 1'b0;
      chk("store_mem", 32'(mem_op), 32'(MEM_DM_WRITE));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'(ST_IDLE));
      chk("arst_mem", 32'(mem_op), 32'(MEM_NONE));
      chk("arst_busy", 32'(busy), 0);
      chk("arst_strobes",
          32'({pc_inc, rst_en, ir_en, branch, done, err}), 0);
      rst_n = 1'b1;
      step();
      chk("arst_after", 32'(state), 32'(ST_IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/ctrl_fsm_param.md
Name: ctrl_fsm_param

Overview:
Parametrised multicycle control unit for the image-downsampling processor; successor to the fixed 8-bit control FSM.
- Adds an asynchronous reset and a start/done/busy handshake in place of the status bus.
- Handles variable-latency memory through a mem_ready stall, with a per-access timeout and error state.
- Adds JPZ and HALT opcodes.
- Sits between the instruction register/zero flag and the datapath, register file, ALU, mux2 and memory.

Parameters:
INSTR_W, 8, instruction width; must be even and at least 8. Opcode field = instr[INSTR_W-1:INSTR_W/2], operand field = instr[INSTR_W/2-1:0].
ALU_OP_W, 4, width of the ALU operation code.
MEM_TIMEOUT, 16, maximum cycles waiting on mem_ready before error; must be at least 2.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  begin execution; sampled in IDLE and ERR only
instr  in  INSTR_W  instruction register contents
z_flag  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
busy  out  1  high in every state except IDLE, ERR
done  out  1  one-cycle pulse on HALT
err  out  1  high while in ERR
pc_inc  out  1  PC increment
rst_en  out  1  register reset strobe
rst_sel  out  INSTR_W/2  register to reset
a_sel, b_sel, c_sel  out  INSTR_W/2 each  bus selects
alu_op  out  ALU_OP_W  ALU operation
mem_op  out  2  NONE / IM_READ / DM_READ / DM_WRITE
ir_en  out  1  instruction register write enable
branch  out  1  branch strobe
mux2_ctrl  out  2  NONE / IMM
state  out  4  current state, for debug

Behaviour:
- Moore outputs: decoded only from the state register and the latched fields opc_q, op_q, dst_q, src_q. No combinational path from any input to any output.
- Select encodings: SEL_NONE = 0 (register 0 is never selected); CSEL_PC = all-ones.
- Reset (async, rst_n=0): state=IDLE; all latched fields and the timeout counter cleared; every output at its NONE/0 value. Reset mid-operation abandons the instruction with no partial strobes.
- IDLE: start=1 -> FETCH.
- FETCH: mem_op=IM_READ, ir_en=1; hold until mem_ready -> DECODE.
- DECODE (1 cycle): pc_inc=1; latch opc_q/op_q from instr; sample z_flag. Next state by opcode:
  - one-word ops CLR, INCR, NOOP -> EXEC
  - LOAD, STORE -> MEM
  - COPY, ADDI, ADDR, SUBI, SUBR, SHL, SHR, OR -> OPERAND
  - JPNZ taken iff z_flag=0; JPZ taken iff z_flag=1; taken -> EXEC, else -> FETCH
  - HALT -> HALT
- OPERAND: mem_op=IM_READ, ir_en=1; on mem_ready latch dst_q=instr[hi], src_q=instr[lo] -> EXEC.
- EXEC (1 cycle) -> FETCH. Outputs by opcode:
  - CLR: rst_en=1, rst_sel=op_q
  - INCR: a=c=op_q, ALU_INCR
  - COPY: a=src_q, c=dst_q, ALU_ABUS
  - ADDI/SUBI/SHL/SHR: a=c=dst_q, mux2=IMM, matching ALU op
  - ADDR/SUBR/OR: a=c=dst_q, b=src_q, matching ALU op
  - JPNZ/JPZ: a=op_q, c=CSEL_PC, ALU_ABUS, branch=1
  - pc_inc=1 for two-word ops only
- MEM: mem_op=DM_READ (LOAD) or DM_WRITE (STORE) held until mem_ready -> FETCH.
- HALT (1 cycle): done=1 -> IDLE.
- Timeout:
  - counter clears on entry to FETCH, OPERAND or MEM and increments each cycle without mem_ready.
  - Reaching MEM_TIMEOUT-1 with mem_ready=0 -> ERR; mem_ready in that same cycle wins.
- ERR: err=1, all strobes off; start=1 -> FETCH with err cleared. The PC is not reset by this unit.
- start outside IDLE/ERR is ignored. Unused opcodes act as NOOP.

Decomposition:
- Shared package/include: opcode values (CLR 0, LOAD 1, STORE 2, COPY 3, INCR 4, ADDI 5, ADDR 6, SUBI 7, SUBR 8, SHL 9, SHR 10, JPNZ 11, OR 12, JPZ 13, HALT 14, NOOP 15); state encodings; ALU_* codes; MEM_*, MUX2_*, SEL_NONE and CSEL_PC constants.
- One sub-module, ctrl_wait_timer: the mem_ready timeout counter (clear, enable, expire).

Test Plan:
- Reset then start with instr=0x6_, operand word 0x23, mem_ready=1 -> EXEC asserts a=2, b=3, c=2, ALU_ADDR, pc_inc=1; DECODE to EXEC in 2 cycles.
- JPNZ 0xB5 with z_flag=0 -> EXEC with branch=1, a=5, c=0xF; repeat with z_flag=1 -> DECODE goes straight to FETCH, branch stays 0.
- LOAD with mem_ready held low 5 cycles -> mem_op=DM_READ for 6 cycles, then FETCH; err=0.
- mem_ready held low in FETCH with MEM_TIMEOUT=16 -> ERR after 16 cycles, err=1; start pulse -> FETCH, err=0.
- HALT 0xE0 -> done high exactly 1 cycle, then IDLE with busy=0; start pulsed during execution is ignored.
- rst_n low asynchronously mid-MEM -> all outputs 0 and state=IDLE before the next clock edge.
